// File: rtl/counter_mod_n.sv
// ---------------------------------------------------------------------------
// counter_mod_n
//
// Free-running modulo-N up-counter with a count enable. The output sequence is
// 0, 1, ..., N-1, 0, ... and advances one step per rising clk edge while ce is
// high. It serves as a building block for clock dividers, sequencers and
// slot/phase indices. Single clock domain, no handshake.
//
// Parameters
//   N    modulus, N >= 2 (default 6). N < 2 stops elaboration.
//   W    derived output width: 1 for N <= 2, else $clog2(N). Not user-set.
//
// Ports
//   clk  in   1  rising-edge clock
//   rst  in   1  asynchronous active-low reset, clears out to 0
//   ce   in   1  count enable, sampled on rising clk
//   out  out  W  current count value, registered
//   tc   out  1  terminal-count strobe, ce & (out == N-1), combinational
//                (present only when COUNTER_MOD_N_TC_EN is defined)
//
// Configuration macro
//   COUNTER_MOD_N_TC_EN  adds the tc output. When undefined the port is absent
//                        and the counter behaves identically.
// ---------------------------------------------------------------------------
module counter_mod_n #(
    parameter  int N = 6,
    localparam int W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    output logic [W-1:0] out
`ifdef COUNTER_MOD_N_TC_EN
    ,
    output logic         tc
`endif
);

    // Elaboration-time guard: a modulus below 2 has no meaningful sequence.
    if (N < 2) begin : g_bad_modulus
        $error("counter_mod_n: modulus N=%0d is illegal, N must be >= 2", N);
    end

    // Terminal value expressed at the full counter width, so the wrap
    // comparison sees every bit of the register.
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next-state logic. Using >= rather than == means any out-of-range value
    // (e.g. a bit flip leaving the register at N or above) returns to 0 on the
    // next enabled edge instead of counting on through illegal codes. For N a
    // power of two, >= LAST only matches LAST itself, so the result equals
    // natural overflow.
    // NOTE: count_d gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        count_d = count_q;
        if (ce) begin
            if (count_q >= LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // The asynchronous clear sits in the sensitivity list so it overrides any
    // clk/ce activity in the same cycle.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its input from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out = count_q;

`ifdef COUNTER_MOD_N_TC_EN
    // High exactly in the cycle whose clk edge wraps the counter to 0. While
    // rst is low count_q is 0 and LAST is at least 1, so tc stays 0.
    assign tc = ce & (count_q == LAST);
`endif

endmodule

// File: tb/tb_counter_mod_n.sv
// ---------------------------------------------------------------------------
// tb_counter_mod_n
//
// Self-checking bench for counter_mod_n. Three instances are exercised:
// N=6 (main sequence, enable gating, asynchronous reset, optional tc),
// N=8 (power-of-two modulus) and N=2 (single-bit counter). Inputs change 1 ns
// after the rising edge and outputs are sampled at the same point, well away
// from the active edge. Expected values are hand-computed tables.
// ---------------------------------------------------------------------------
module tb_counter_mod_n;

    logic       clk;
    logic       rst;
    logic       ce6;
    logic       ce8;
    logic       ce2;
    logic [2:0] out6;
    logic [2:0] out8;
    logic [0:0] out2;
`ifdef COUNTER_MOD_N_TC_EN
    logic       tc6;
    logic       tc8;
    logic       tc2;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    counter_mod_n #(.N(6)) u_dut6 (
        .clk (clk),
        .rst (rst),
        .ce  (ce6),
        .out (out6)
`ifdef COUNTER_MOD_N_TC_EN
        ,
        .tc  (tc6)
`endif
    );

    counter_mod_n #(.N(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .ce  (ce8),
        .out (out8)
`ifdef COUNTER_MOD_N_TC_EN
        ,
        .tc  (tc8)
`endif
    );

    counter_mod_n #(.N(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .ce  (ce2),
        .out (out2)
`ifdef COUNTER_MOD_N_TC_EN
        ,
        .tc  (tc2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset for a couple of edges with ce high (must be ignored),
    // checking out stays 0, then release it just after an edge.
    task automatic test_reset();
        rst = 1'b0;
        ce6 = 1'b1;
        ce8 = 1'b1;
        ce2 = 1'b1;
        #2;
        total_cnt++;
        if (out6 !== 3'd0) $display("FAIL reset_out6: got %0d expected 0", out6);
        else pass_cnt++;
        total_cnt++;
        if (out8 !== 3'd0) $display("FAIL reset_out8: got %0d expected 0", out8);
        else pass_cnt++;
        total_cnt++;
        if (out2 !== 1'd0) $display("FAIL reset_out2: got %0d expected 0", out2);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (out6 !== 3'd0) $display("FAIL reset_held_out6: got %0d expected 0", out6);
        else pass_cnt++;
`ifdef COUNTER_MOD_N_TC_EN
        total_cnt++;
        if (tc6 !== 1'b0) $display("FAIL reset_tc6: got %0b expected 0", tc6);
        else pass_cnt++;
`endif
        ce6 = 1'b0;
        ce8 = 1'b0;
        ce2 = 1'b0;
        rst = 1'b1;
    endtask

    // N=6, ce=1: 1,2,3,4,5,0,1,2,3,4,5,0,1 after successive edges.
    task automatic test_count_wrap();
        logic [2:0] exp_out [13] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1,
                                     3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        logic       exp_tc  [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ce6 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            total_cnt++;
            if (out6 !== exp_out[i])
                $display("FAIL count_wrap[%0d]: got %0d expected %0d", i, out6, exp_out[i]);
            else pass_cnt++;
`ifdef COUNTER_MOD_N_TC_EN
            total_cnt++;
            if (tc6 !== exp_tc[i])
                $display("FAIL tc_pulse[%0d]: got %0b expected %0b", i, tc6, exp_tc[i]);
            else pass_cnt++;
`else
            if (exp_tc[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    // From out=1: one enabled edge to 2, then ce 1,0,0,1 -> 3,3,3,4.
    // Then advance to 5 and drop ce: out holds at 5 and tc stays low.
    task automatic test_ce_gating();
        logic       ce_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] exp_out [4] = '{3'd3, 3'd3, 3'd3, 3'd4};
        ce6 = 1'b1;
        step();
        total_cnt++;
        if (out6 !== 3'd2) $display("FAIL ce_setup: got %0d expected 2", out6);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            ce6 = ce_pat[i];
            step();
            total_cnt++;
            if (out6 !== exp_out[i])
                $display("FAIL ce_gate[%0d]: got %0d expected %0d", i, out6, exp_out[i]);
            else pass_cnt++;
        end
        ce6 = 1'b1;
        step();
        ce6 = 1'b0;
        #1;
        total_cnt++;
        if (out6 !== 3'd5) $display("FAIL ce_at_last: got %0d expected 5", out6);
        else pass_cnt++;
`ifdef COUNTER_MOD_N_TC_EN
        total_cnt++;
        if (tc6 !== 1'b0) $display("FAIL tc_ce_low: got %0b expected 0", tc6);
        else pass_cnt++;
`endif
        step();
        total_cnt++;
        if (out6 !== 3'd5) $display("FAIL ce_hold_last: got %0d expected 5", out6);
        else pass_cnt++;
    endtask

    // From out=5: five enabled edges to reach 4, then pull rst low mid-cycle.
    task automatic test_async_reset();
        ce6 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        total_cnt++;
        if (out6 !== 3'd4) $display("FAIL async_setup: got %0d expected 4", out6);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (out6 !== 3'd0) $display("FAIL async_clear: got %0d expected 0", out6);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out6 !== 3'd0) $display("FAIL async_hold: got %0d expected 0", out6);
        else pass_cnt++;
        rst = 1'b1;
        ce6 = 1'b0;
        step();
        total_cnt++;
        if (out6 !== 3'd0) $display("FAIL async_release_noce: got %0d expected 0", out6);
        else pass_cnt++;
        ce6 = 1'b1;
        step();
        total_cnt++;
        if (out6 !== 3'd1) $display("FAIL async_first_count: got %0d expected 1", out6);
        else pass_cnt++;
        ce6 = 1'b0;
    endtask

    // N=8 from reset, ce=1 for 10 edges: 1..7,0,1,2.
    task automatic test_pow2();
        logic [2:0] exp_out [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                     3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        rst = 1'b0;
        #2;
        rst = 1'b1;
        ce8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total_cnt++;
            if (out8 !== exp_out[i])
                $display("FAIL pow2[%0d]: got %0d expected %0d", i, out8, exp_out[i]);
            else pass_cnt++;
        end
        ce8 = 1'b0;
    endtask

    // N=2 from reset, ce=1: 1,0,1,0.
    task automatic test_n2();
        logic [0:0] exp_out [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b0;
        #2;
        total_cnt++;
        if (out2 !== 1'd0) $display("FAIL n2_reset: got %0d expected 0", out2);
        else pass_cnt++;
        rst = 1'b1;
        ce2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (out2 !== exp_out[i])
                $display("FAIL n2[%0d]: got %0d expected %0d", i, out2, exp_out[i]);
            else pass_cnt++;
        end
        ce2 = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ce6 = 1'b0;
        ce8 = 1'b0;
        ce2 = 1'b0;
        step();
        test_reset();
        test_count_wrap();
        test_ce_gating();
        test_async_reset();
        test_pow2();
        test_n2();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
